// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed, checksummed byte stream and writes big-endian
// 16-bit words into instruction memory, holding the CPU in reset until verified.
module imem_boot_loader #(
    parameter int MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        imem_wr_en,
    output logic [15:0] imem_wr_addr,
    output logic [15:0] imem_wr_data,
    output logic        cpu_rst_n,
    output logic        load_done,
    output logic        load_err
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_hi_q, cnt_hi_d;
    logic [15:0] word_cnt_q, word_cnt_d;
    logic [15:0] word_idx_q, word_idx_d;
    logic [7:0]  data_hi_q, data_hi_d;
    logic [7:0]  sum_q, sum_d;

    logic        in_ready_d;
    logic        wr_en_d;
    logic [15:0] wr_addr_d;
    logic [15:0] wr_data_d;
    logic        done_d;
    logic        err_d;

    logic        xfer;
    logic [15:0] count_word;
    logic [15:0] word_idx_inc;

    assign xfer         = in_valid && in_ready;
    assign count_word   = {cnt_hi_q, in_data};
    assign word_idx_inc = word_idx_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        cnt_hi_d   = cnt_hi_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        data_hi_d  = data_hi_q;
        sum_d      = sum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = imem_wr_addr;
        wr_data_d  = imem_wr_data;

        case (state_q)
            S_CNT_HI: begin
                if (xfer) begin
                    cnt_hi_d = in_data;
                    sum_d    = sum_q + in_data;
                    state_d  = S_CNT_LO;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    word_cnt_d = count_word;
                    word_idx_d = '0;
                    sum_d      = sum_q + in_data;
                    if (count_word == 16'd0)
                        state_d = S_CSUM;
                    else if (count_word > 16'(MAX_WORDS))
                        state_d = S_ERROR;
                    else
                        state_d = S_DATA_HI;
                end
            end
            S_DATA_HI: begin
                if (xfer) begin
                    data_hi_d = in_data;
                    sum_d     = sum_q + in_data;
                    state_d   = S_DATA_LO;
                end
            end
            S_DATA_LO: begin
                if (xfer) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = {word_idx_q[14:0], 1'b0};
                    wr_data_d  = {data_hi_q, in_data};
                    word_idx_d = word_idx_inc;
                    sum_d      = sum_q + in_data;
                    state_d    = (word_idx_inc == word_cnt_q) ? S_CSUM : S_DATA_HI;
                end
            end
            S_CSUM: begin
                if (xfer)
                    state_d = (in_data == sum_q) ? S_DONE : S_ERROR;
            end
            default: state_d = state_q;
        endcase

        // Status outputs are registered images of the state being entered.
        in_ready_d = (state_d != S_DONE) && (state_d != S_ERROR);
        done_d     = (state_d == S_DONE);
        err_d      = (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_CNT_HI;
            cnt_hi_q     <= '0;
            word_cnt_q   <= '0;
            word_idx_q   <= '0;
            data_hi_q    <= '0;
            sum_q        <= '0;
            in_ready     <= 1'b0;
            imem_wr_en   <= 1'b0;
            imem_wr_addr <= '0;
            imem_wr_data <= '0;
            cpu_rst_n    <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_hi_q     <= cnt_hi_d;
            word_cnt_q   <= word_cnt_d;
            word_idx_q   <= word_idx_d;
            data_hi_q    <= data_hi_d;
            sum_q        <= sum_d;
            in_ready     <= in_ready_d;
            imem_wr_en   <= wr_en_d;
            imem_wr_addr <= wr_addr_d;
            imem_wr_data <= wr_data_d;
            cpu_rst_n    <= done_d;
            load_done    <= done_d;
            load_err     <= err_d;
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: table of frames plus hand-written
// sequences for maximum-size image and reset in the middle of a load.
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready;
    logic        imem_wr_en;
    logic [15:0] imem_wr_addr;
    logic [15:0] imem_wr_data;
    logic        cpu_rst_n;
    logic        load_done;
    logic        load_err;

    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];

    imem_boot_loader #(.MAX_WORDS(256)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .imem_wr_en   (imem_wr_en),
        .imem_wr_addr (imem_wr_addr),
        .imem_wr_data (imem_wr_data),
        .cpu_rst_n    (cpu_rst_n),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_wr_en) begin
            wr_a.push_back(imem_wr_addr);
            wr_d.push_back(imem_wr_data);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        int unsigned nbytes;
        logic [63:0] bytes;   // byte i at [63-8*i -: 8]
        bit          stall;
        int unsigned nwr;
        logic [31:0] wa;      // write j at [31-16*j -: 16]
        logic [31:0] wd;
        logic        done;
        logic        err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        int unsigned w;
        if (stall) repeat ($urandom_range(1, 3)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout actual=0 required=1");
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},   32'd0);
        chk({tag, "_wr_en"},     {31'd0, imem_wr_en}, 32'd0);
        chk({tag, "_wr_addr"},   {16'd0, imem_wr_addr}, 32'd0);
        chk({tag, "_wr_data"},   {16'd0, imem_wr_data}, 32'd0);
        chk({tag, "_cpu_rst_n"}, {31'd0, cpu_rst_n},  32'd0);
        chk({tag, "_done"},      {31'd0, load_done},  32'd0);
        chk({tag, "_err"},       {31'd0, load_err},   32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;
        wr_a.delete();
        wr_d.delete();
        chk("ready_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1 chk("ready_after_edge", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        vecs[0] = '{"nominal", 7, 64'h00022001_4C82F100, 1'b0, 2, 32'h0000_0002, 32'h2001_4C82, 1'b1, 1'b0};
        vecs[1] = '{"empty",   3, 64'h000000_0000000000, 1'b0, 0, 32'h0, 32'h0, 1'b1, 1'b0};
        vecs[2] = '{"oversize",2, 64'h0101_000000000000, 1'b0, 0, 32'h0, 32'h0, 1'b0, 1'b1};
        vecs[3] = '{"badcsum", 7, 64'h00022001_4C82F000, 1'b0, 2, 32'h0000_0002, 32'h2001_4C82, 1'b0, 1'b1};
        vecs[4] = '{"stalled", 7, 64'h00022001_4C82F100, 1'b1, 2, 32'h0000_0002, 32'h2001_4C82, 1'b1, 1'b0};

        for (int v = 0; v < 5; v++) begin
            do_reset();
            for (int i = 0; i < int'(vecs[v].nbytes); i++) begin
                if (i == int'(vecs[v].nbytes) - 1) begin
                    chk({vecs[v].name, "_done_early"}, {31'd0, load_done}, 32'd0);
                    chk({vecs[v].name, "_err_early"},  {31'd0, load_err},  32'd0);
                end
                send_byte(vecs[v].bytes[63-8*i -: 8], vecs[v].stall);
            end
            // status must be visible right after the final transfer edge
            chk({vecs[v].name, "_done"},      {31'd0, load_done}, {31'd0, vecs[v].done});
            chk({vecs[v].name, "_err"},       {31'd0, load_err},  {31'd0, vecs[v].err});
            chk({vecs[v].name, "_cpu_rst_n"}, {31'd0, cpu_rst_n}, {31'd0, vecs[v].done});
            chk({vecs[v].name, "_in_ready"},  {31'd0, in_ready},  32'd0);
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 8'h55;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk({vecs[v].name, "_refuse"}, {31'd0, in_ready}, 32'd0);
            end
            in_valid = 1'b0;
            @(negedge clk);
            chk({vecs[v].name, "_done_hold"}, {31'd0, load_done}, {31'd0, vecs[v].done});
            chk({vecs[v].name, "_err_hold"},  {31'd0, load_err},  {31'd0, vecs[v].err});
            chk({vecs[v].name, "_nwr"}, wr_a.size(), vecs[v].nwr);
            for (int j = 0; j < int'(vecs[v].nwr) && j < wr_a.size(); j++) begin
                chk({vecs[v].name, "_wr_addr"}, {16'd0, wr_a[j]}, {16'd0, vecs[v].wa[31-16*j -: 16]});
                chk({vecs[v].name, "_wr_data"}, {16'd0, wr_d[j]}, {16'd0, vecs[v].wd[31-16*j -: 16]});
            end
        end

        // Maximum-size image: N = 256 is accepted, last write lands at 0x01FE.
        begin
            logic [7:0]  sum;
            logic [7:0]  hi;
            logic [7:0]  lo;
            int unsigned bad;
            do_reset();
            sum = 8'h01;
            send_byte(8'h01, 1'b0);
            send_byte(8'h00, 1'b0);
            for (int k = 0; k < 256; k++) begin
                hi = 8'(k) ^ 8'hA5;
                lo = 8'(k);
                sum = sum + hi + lo;
                send_byte(hi, 1'b0);
                send_byte(lo, 1'b0);
            end
            send_byte(sum, 1'b0);
            chk("max_done", {31'd0, load_done}, 32'd1);
            chk("max_err",  {31'd0, load_err},  32'd0);
            @(negedge clk);
            chk("max_nwr", wr_a.size(), 32'd256);
            bad = 0;
            for (int k = 0; k < 256 && k < wr_a.size(); k++) begin
                if (wr_a[k] !== 16'(2 * k) || wr_d[k] !== {8'(k) ^ 8'hA5, 8'(k)}) bad++;
            end
            chk("max_words_bad", bad, 32'd0);
        end

        // Reset pulse right after the first write, then a full reload.
        begin
            logic [63:0] nom;
            nom = 64'h00022001_4C82F100;
            do_reset();
            for (int i = 0; i < 4; i++) send_byte(nom[63-8*i -: 8], 1'b0);
            chk("mid_first_wr_en",   {31'd0, imem_wr_en}, 32'd1);
            chk("mid_first_wr_data", {16'd0, imem_wr_data}, 32'h2001);
            #2 rst_n = 1'b0;
            #1 chk_reset_vals("mid_reset");
            @(negedge clk);
            rst_n = 1'b1;
            wr_a.delete();
            wr_d.delete();
            for (int i = 0; i < 7; i++) send_byte(nom[63-8*i -: 8], 1'b0);
            chk("mid_done",      {31'd0, load_done}, 32'd1);
            chk("mid_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
            @(negedge clk);
            chk("mid_nwr", wr_a.size(), 32'd2);
            if (wr_a.size() >= 2) begin
                chk("mid_wr0_addr", {16'd0, wr_a[0]}, 32'h0000);
                chk("mid_wr0_data", {16'd0, wr_d[0]}, 32'h2001);
                chk("mid_wr1_addr", {16'd0, wr_a[1]}, 32'h0002);
                chk("mid_wr1_data", {16'd0, wr_d[1]}, 32'h4C82);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time writer for the 16-bit single-cycle MIPS instruction memory. It receives a framed byte stream over a valid/ready interface and assembles big-endian 16-bit instruction words. It writes them to consecutive even byte addresses of instruction memory, starting at 0x0000, and holds the CPU in reset until a complete, checksum-verified image is loaded. It sits between the external loader stream and the instruction memory's write port; the CPU's fetch path is its reader.

## Interface

- MAX_WORDS, 256, instruction memory capacity in 16-bit words; a larger header count is an error.
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  byte on in_data is valid.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
- imem_wr_en  output  1  one-cycle instruction memory write strobe.
- imem_wr_addr  output  16  byte address of the write; always even.
- imem_wr_data  output  16  instruction word.
- cpu_rst_n  output  1  active-low reset to the CPU; low until the load completes.
- load_done  output  1  image loaded and verified.
- load_err  output  1  load failed (oversize count or bad checksum).

## Operation

- Frame layout: CNT_HI, CNT_LO (16-bit word count N), then N words each sent high byte first, then one checksum byte.
- Checksum: 8-bit modulo-256 sum of every byte preceding the checksum byte, including both count bytes. The checksum byte must equal that sum.
- State machine, one state per expected byte:
  - CNT_HI -> CNT_LO
  - CNT_LO -> DATA_HI if 1 ≤ N ≤ MAX_WORDS; CSUM if N == 0; ERROR if N > MAX_WORDS
  - DATA_HI -> DATA_LO
  - DATA_LO -> DATA_HI while words remain; CSUM after word N
  - CSUM -> DONE on match; ERROR on mismatch
- A state advances only on a transfer cycle (in_valid && in_ready). Cycles with in_valid low are ignored with no timeout.
- Each DATA_LO transfer completes a word {hi, lo}. The word is written to address 2*k, where k is the 0-based word index, so addresses match the CPU's PC+2 sequencing.
- DONE and ERROR are terminal. They are left only via rst_n, and all bytes presented in them are refused (in_ready = 0).
- Words written before an ERROR are not erased. cpu_rst_n stays low in ERROR.
- Word counter and address are 16 bits wide. Since N ≤ MAX_WORDS, the address never wraps.

## Timing

- All outputs are registered.
- Reset values: in_ready 0, imem_wr_en 0, imem_wr_addr 0x0000, imem_wr_data 0x0000, cpu_rst_n 0, load_done 0, load_err 0.
- in_ready goes to 1 on the first rising edge after rst_n deasserts. It stays 1 through all receive states and drops on the same edge that enters DONE or ERROR.
- Write latency: imem_wr_en is high for exactly the one cycle after the DATA_LO transfer edge, with imem_wr_addr and imem_wr_data valid in that cycle. Back-to-back words therefore produce strobes at most once every 2 cycles.
- DONE: load_done and cpu_rst_n go to 1 one cycle after the checksum transfer and stay high. The last word's write strobe always precedes or coincides with that edge.
- ERROR: load_err goes to 1 one cycle after the offending transfer and stays high.
- Reset mid-load: when rst_n asserts, all outputs and the state return to their reset values immediately (asynchronously). The next byte after release is treated as CNT_HI.

## Test plan

- Nominal, MAX_WORDS=256:
  - Stimulus: bytes 00 02 20 01 4C 82 F1.
  - Required: writes (0x0000, 0x2001) then (0x0002, 0x4C82); load_done=1 and cpu_rst_n=1 one cycle after the F1 transfer; load_err=0; in_ready=0 afterwards.
- Empty image:
  - Stimulus: bytes 00 00 00.
  - Required: no imem_wr_en pulses; load_done=1; cpu_rst_n=1.
- Oversize count:
  - Stimulus: bytes 01 01, i.e. N=257 > 256.
  - Required: load_err=1 one cycle after the second byte; in_ready=0; no writes; cpu_rst_n stays 0.
- Bad checksum:
  - Stimulus: the nominal frame with F0 as the last byte.
  - Required: both writes occur; load_err=1; load_done=0; cpu_rst_n=0.
- Stalled stream:
  - Stimulus: the nominal frame with in_valid deasserted for 1–3 random cycles between bytes.
  - Required: identical writes and identical final outputs.
- Reset mid-load:
  - Stimulus: pulse rst_n low after the first write of the nominal frame, then resend the full nominal frame.
  - Required: all outputs return to reset values during the pulse; writes restart at 0x0000; load_done=1 at the end.
